dsc_op_sequencer: RTL and testbench

DSC_OP_SEQUENCER -- requirements
Module: dsc_op_sequencer

---
 rtl/dsc_op_sequencer.sv | 119 +++++++++++
 tb/tb_dsc_op_sequencer.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dsc_op_sequencer.sv
// Sequences a DSC core through load, run and drain phases and returns the core
// result, the number of run cycles used and a truncation flag on a valid/ready port.
module dsc_op_sequencer #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_INPUTS = 2,
    parameter int WXIP1      = 17
) (
    input  logic                             gclk,
    input  logic                             rst_n,
    input  logic                             req_valid,
    output logic                             req_ready,
    input  logic [NUM_INPUTS*DATA_WIDTH-1:0] req_data,
    input  logic [WXIP1-1:0]                 req_budget,
    output logic                             core_rst,
    output logic                             core_en,
    output logic [NUM_INPUTS*DATA_WIDTH-1:0] core_data,
    input  logic                             core_op_finished,
    input  logic [WXIP1-1:0]                 core_data_out,
    output logic                             rsp_valid,
    input  logic                             rsp_ready,
    output logic [WXIP1-1:0]                 rsp_result,
    output logic [WXIP1-1:0]                 rsp_cycles,
    output logic                             rsp_truncated,
    output logic                             busy
);

    typedef enum logic [2:0] {IDLE, LOAD, RUN, DRAIN, RESP} state_t;

    localparam logic [WXIP1-1:0] COUNT_MAX = '1;

    state_t           state;
    logic [WXIP1-1:0] budget;
    logic [WXIP1-1:0] count;
    logic [WXIP1-1:0] count_inc;
    logic             truncated;
    logic             hit_budget;
    logic             hit_max;

    // The stop conditions look at the count this RUN cycle will end with.
    always_comb begin
        count_inc  = (count == COUNT_MAX) ? count : count + 1'b1;
        hit_budget = (budget != '0) && (count_inc == budget);
        hit_max    = (count_inc == COUNT_MAX);
    end

    always_ff @(posedge gclk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            budget        <= '0;
            count         <= '0;
            truncated     <= 1'b0;
            req_ready     <= 1'b1;
            busy          <= 1'b0;
            core_rst      <= 1'b1;
            core_en       <= 1'b0;
            core_data     <= '0;
            rsp_valid     <= 1'b0;
            rsp_result    <= '0;
            rsp_cycles    <= '0;
            rsp_truncated <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        core_data <= req_data;
                        budget    <= req_budget;
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        state     <= LOAD;
                    end
                end
                LOAD: begin
                    count    <= '0;
                    core_rst <= 1'b0;
                    core_en  <= 1'b1;
                    state    <= RUN;
                end
                RUN: begin
                    count <= count_inc;
                    // A finish in the same cycle as a limit still counts as a clean finish.
                    if (core_op_finished) begin
                        truncated <= 1'b0;
                        core_en   <= 1'b0;
                        state     <= DRAIN;
                    end else if (hit_budget || hit_max) begin
                        truncated <= 1'b1;
                        core_en   <= 1'b0;
                        state     <= DRAIN;
                    end
                end
                DRAIN: begin
                    rsp_result    <= core_data_out;
                    rsp_cycles    <= count;
                    rsp_truncated <= truncated;
                    rsp_valid     <= 1'b1;
                    state         <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        busy      <= 1'b0;
                        core_rst  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                    busy      <= 1'b0;
                    core_rst  <= 1'b1;
                    core_en   <= 1'b0;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dsc_op_sequencer.sv
// Scoreboard bench for dsc_op_sequencer: a stub core, a stimulus task that queues
// model expectations, and a monitor that checks every response against them.
module tb_dsc_op_sequencer;

    localparam int WX = 17;
    localparam int WS = 4;

    typedef struct {
        int          result;
        int          cycles;
        bit          trunc;
        int          acc;
        logic [15:0] data;
    } exp_t;

    logic          gclk;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic [15:0]   req_data;
    logic [WX-1:0] req_budget;
    logic          core_rst;
    logic          core_en;
    logic [15:0]   core_data;
    logic          core_op_finished;
    logic [WX-1:0] core_data_out;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [WX-1:0] rsp_result;
    logic [WX-1:0] rsp_cycles;
    logic          rsp_truncated;
    logic          busy;

    logic          s_req_valid;
    logic          s_req_ready;
    logic [15:0]   s_req_data;
    logic [WS-1:0] s_req_budget;
    logic          s_core_rst;
    logic          s_core_en;
    logic [15:0]   s_core_data;
    logic          s_core_op_finished;
    logic [WS-1:0] s_core_data_out;
    logic          s_rsp_valid;
    logic          s_rsp_ready;
    logic [WS-1:0] s_rsp_result;
    logic [WS-1:0] s_rsp_cycles;
    logic          s_rsp_truncated;
    logic          s_busy;

    int            n_vec = 0;
    int            n_err = 0;
    int            cyc;
    int            hs_cyc = -10;
    exp_t          exp_q[$];
    int            stub_fin;
    bit            stub_ops;
    bit            hold;
    logic          noise;
    logic [WX-1:0] run_cnt;

    dsc_op_sequencer #(.DATA_WIDTH(8), .NUM_INPUTS(2), .WXIP1(WX)) dut (
        .gclk(gclk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data), .req_budget(req_budget),
        .core_rst(core_rst), .core_en(core_en), .core_data(core_data),
        .core_op_finished(core_op_finished), .core_data_out(core_data_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_cycles(rsp_cycles), .rsp_truncated(rsp_truncated), .busy(busy)
    );

    dsc_op_sequencer #(.DATA_WIDTH(8), .NUM_INPUTS(2), .WXIP1(WS)) dut_sat (
        .gclk(gclk), .rst_n(rst_n),
        .req_valid(s_req_valid), .req_ready(s_req_ready), .req_data(s_req_data), .req_budget(s_req_budget),
        .core_rst(s_core_rst), .core_en(s_core_en), .core_data(s_core_data),
        .core_op_finished(s_core_op_finished), .core_data_out(s_core_data_out),
        .rsp_valid(s_rsp_valid), .rsp_ready(s_rsp_ready), .rsp_result(s_rsp_result),
        .rsp_cycles(s_rsp_cycles), .rsp_truncated(s_rsp_truncated), .busy(s_busy)
    );

    initial begin
        gclk = 1'b0;
        forever #5 gclk = ~gclk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge gclk);
            cyc++;
        end
    end

    // Stub core: counts enabled cycles, finishes in run cycle stub_fin (0 = never),
    // and drives random finish noise whenever it is not enabled.
    always_ff @(posedge gclk) begin
        if (core_rst) run_cnt <= '0;
        else if (core_en) run_cnt <= run_cnt + 1'b1;
    end

    always_comb begin
        core_op_finished = core_en ? (stub_fin != 0 && int'(run_cnt) == stub_fin - 1) : noise;
        core_data_out    = run_cnt + (stub_ops ? ({9'd0, core_data[7:0]} * {9'd0, core_data[15:8]}) : '0);
    end

    initial begin
        rsp_ready = 1'b0;
        noise     = 1'b0;
        forever begin
            @(posedge gclk);
            #2;
            rsp_ready = hold ? 1'b0 : ($urandom_range(0, 3) != 0);
            noise     = $urandom_range(0, 1) != 0;
        end
    end

    task automatic checkOutput(input string name, input longint act, input longint req);
        n_vec++;
        if (act != req) begin
            n_err++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic reportFail(input string name, input string what);
        n_vec++;
        n_err++;
        $display("[TB] FAIL %s: %s (cycle %0d)", name, what, cyc);
    endtask

    // Reference rule: the run stops at the earliest of finish, budget and counter
    // saturation, and a finish that is not later than the limit wins.
    function automatic void model(input int budget, input int fin, input int cmax,
                                  output int k, output bit tr);
        int limit;
        limit = cmax;
        if (budget != 0 && budget < limit) limit = budget;
        if (fin != 0 && fin <= limit) begin
            k  = fin;
            tr = 1'b0;
        end else begin
            k  = limit;
            tr = 1'b1;
        end
    endfunction

    task automatic applyStimulus(input int a, input int b, input int budget, input int fin,
                                 input bit ops, input bit after_hs);
        exp_t e;
        int   k;
        bit   tr;
        int   waited;
        @(negedge gclk);
        req_data   = {8'(b), 8'(a)};
        req_budget = WX'(budget);
        req_valid  = 1'b1;
        waited     = 0;
        while (!req_ready && waited < 400) begin
            @(negedge gclk);
            waited++;
        end
        if (!req_ready) begin
            reportFail("accept_timeout", "req_ready stayed 0, required 1");
            req_valid = 1'b0;
            return;
        end
        if (after_hs) checkOutput("accept_after_rsp", cyc, hs_cyc + 1);
        model(budget, fin, (1 << WX) - 1, k, tr);
        e.cycles = k;
        e.trunc  = tr;
        e.result = (k + (ops ? a * b : 0)) % (1 << WX);
        e.acc    = cyc;
        e.data   = {8'(b), 8'(a)};
        @(posedge gclk);
        #1;
        exp_q.push_back(e);
        req_valid = 1'b0;
        stub_fin  = fin;
        stub_ops  = ops;
    endtask

    task automatic waitDrain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 2000) begin
            @(negedge gclk);
            t++;
        end
        if (exp_q.size() != 0) reportFail("drain_timeout", "response never handshaken");
        @(negedge gclk);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_req_ready"}, req_ready, 1);
        checkOutput({tag, "_busy"}, busy, 0);
        checkOutput({tag, "_core_rst"}, core_rst, 1);
        checkOutput({tag, "_core_en"}, core_en, 0);
        checkOutput({tag, "_core_data"}, core_data, 0);
        checkOutput({tag, "_rsp_valid"}, rsp_valid, 0);
        checkOutput({tag, "_rsp_result"}, rsp_result, 0);
        checkOutput({tag, "_rsp_cycles"}, rsp_cycles, 0);
        checkOutput({tag, "_rsp_trunc"}, rsp_truncated, 0);
    endtask

    // Monitor: checks latency and held operands when a response appears, stability
    // while it is back-pressured, and contents at the handshake.
    initial begin
        exp_t        e;
        bit          prev_valid;
        logic [WX:0] held_res;
        logic [WX:0] held_cyc;
        prev_valid = 1'b0;
        held_res   = '0;
        held_cyc   = '0;
        forever begin
            @(negedge gclk);
            if (!rst_n) begin
                prev_valid = 1'b0;
                continue;
            end
            if (rsp_valid && !prev_valid) begin
                held_res = {rsp_truncated, rsp_result};
                held_cyc = {1'b0, rsp_cycles};
                if (exp_q.size() == 0) begin
                    reportFail("unexpected_rsp", "rsp_valid=1 with no operation outstanding");
                end else begin
                    checkOutput("latency", cyc - exp_q[0].acc, exp_q[0].cycles + 3);
                    checkOutput("core_data_hold", core_data, exp_q[0].data);
                end
            end
            if (rsp_valid) begin
                checkOutput("req_ready_in_resp", req_ready, 0);
                if (prev_valid) begin
                    checkOutput("rsp_hold_result", {rsp_truncated, rsp_result}, held_res);
                    checkOutput("rsp_hold_cycles", {1'b0, rsp_cycles}, held_cyc);
                end
            end
            if (rsp_valid && rsp_ready && exp_q.size() != 0) begin
                e = exp_q.pop_front();
                checkOutput("rsp_result", rsp_result, e.result);
                checkOutput("rsp_cycles", rsp_cycles, e.cycles);
                checkOutput("rsp_truncated", rsp_truncated, e.trunc);
                hs_cyc = cyc;
            end
            prev_valid = rsp_valid;
        end
    end

    initial begin
        int t;
        int acc;
        int k;
        bit tr;
        rst_n        = 1'b0;
        req_valid    = 1'b0;
        req_data     = '0;
        req_budget   = '0;
        stub_fin     = 0;
        stub_ops     = 1'b0;
        hold         = 1'b0;
        s_req_valid  = 1'b0;
        s_req_data   = 16'h0201;
        s_req_budget = '0;
        s_core_op_finished = 1'b0;
        s_core_data_out    = 4'd9;
        s_rsp_ready        = 1'b1;

        repeat (3) @(negedge gclk);
        checkResetValues("por");
        rst_n = 1'b1;

        // Normal finish, budget truncation, and finish coinciding with the budget.
        applyStimulus(3, 5, 0, 15, 1'b0, 1'b0);
        waitDrain();
        applyStimulus(3, 5, 8, 15, 1'b0, 1'b0);
        waitDrain();
        applyStimulus(3, 5, 15, 15, 1'b0, 1'b0);
        waitDrain();

        // Back-pressure with the next request already waiting.
        hold = 1'b1;
        applyStimulus(11, 13, 0, 6, 1'b1, 1'b0);
        fork
            begin
                t = 0;
                while (!rsp_valid && t < 200) begin
                    @(negedge gclk);
                    t++;
                end
                repeat (5) @(negedge gclk);
                hold = 1'b0;
            end
            applyStimulus(7, 9, 0, 4, 1'b1, 1'b1);
        join
        waitDrain();

        // Reset pulse in the fourth run cycle discards the operation.
        applyStimulus(21, 2, 20, 0, 1'b1, 1'b0);
        repeat (5) @(negedge gclk);
        checkOutput("in_run_before_reset", core_en, 1);
        rst_n = 1'b0;
        #1;
        checkResetValues("midrun");
        exp_q.delete();
        @(negedge gclk);
        rst_n = 1'b1;
        repeat (30) @(negedge gclk);
        applyStimulus(3, 5, 0, 15, 1'b0, 1'b0);
        waitDrain();

        // Saturation on the narrow-count instance.
        @(negedge gclk);
        s_req_valid = 1'b1;
        checkOutput("sat_req_ready", s_req_ready, 1);
        acc = cyc;
        @(posedge gclk);
        #1;
        s_req_valid = 1'b0;
        t = 0;
        @(negedge gclk);
        while (!s_rsp_valid && t < 100) begin
            @(negedge gclk);
            t++;
        end
        if (!s_rsp_valid) begin
            reportFail("sat_timeout", "s_rsp_valid stayed 0");
        end else begin
            model(0, 0, (1 << WS) - 1, k, tr);
            checkOutput("sat_latency", cyc - acc, k + 3);
            checkOutput("sat_cycles", s_rsp_cycles, k);
            checkOutput("sat_truncated", s_rsp_truncated, tr);
            checkOutput("sat_result", s_rsp_result, 9);
        end
        @(negedge gclk);

        // Randomized traffic, issued back to back.
        for (int i = 0; i < 25; i++) begin
            int a;
            int b;
            int bud;
            int fin;
            a   = $urandom_range(0, 255);
            b   = $urandom_range(0, 255);
            bud = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 30);
            fin = $urandom_range(0, 35);
            if (bud == 0 && fin == 0) fin = $urandom_range(1, 35);
            applyStimulus(a, b, bud, fin, $urandom_range(0, 1) != 0, 1'b0);
        end
        waitDrain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
